// File: rtl/csr_access_unit.sv
// csr_access_unit: CSR read-modify-write sequencer (IDLE/READ/WRITE/RESP); define CSR_PRIV_CHECK_EN to add the privilege-level legality check
module csr_access_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic        req_imm,
    input  logic [11:0] req_csr,
    input  logic [31:0] req_rs1_data,
    input  logic [4:0]  req_zimm,
    input  logic        req_rs1_x0,
    input  logic        req_rd_x0,
    input  logic        flush,
    output logic [11:0] csr_read_index,
    input  logic [31:0] csr_data_r,
    output logic [11:0] csr_write_index,
    output logic        csr_write,
    output logic [31:0] csr_data_w,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_data,
    output logic        resp_ill,
    input  logic [1:0]  cur_priv
);
    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;
    state_t      state_q, state_d;
    logic [1:0]  op_q, op_d;
    logic        imm_q, imm_d;
    logic [11:0] csr_q, csr_d;
    logic [31:0] rs1_q, rs1_d;
    logic [4:0]  zimm_q, zimm_d;
    logic        rs1_x0_q, rs1_x0_d;
    logic        rd_x0_q, rd_x0_d;
    logic [31:0] old_q, old_d;
    logic        accept, suppress, priv_ill, ill, do_write;
    logic [31:0] src, new_val;
`ifdef CSR_PRIV_CHECK_EN
    logic [1:0]  priv_q, priv_d;
    assign priv_d   = accept ? cur_priv : priv_q;
    assign priv_ill = csr_q[9:8] > priv_q;
    always_ff @(posedge clk) begin
        priv_q <= rst ? 2'b00 : priv_d;
    end
`else
    logic unused_priv;
    assign unused_priv = ^cur_priv;
    assign priv_ill    = 1'b0;
`endif
    always_ff @(posedge clk) begin
        state_q <= rst ? IDLE : state_d;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q     <= '0;
            imm_q    <= '0;
            csr_q    <= '0;
            rs1_q    <= '0;
            zimm_q   <= '0;
            rs1_x0_q <= '0;
            rd_x0_q  <= '0;
            old_q    <= '0;
        end else begin
            op_q     <= op_d;
            imm_q    <= imm_d;
            csr_q    <= csr_d;
            rs1_q    <= rs1_d;
            zimm_q   <= zimm_d;
            rs1_x0_q <= rs1_x0_d;
            rd_x0_q  <= rd_x0_d;
            old_q    <= old_d;
        end
    end
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = accept ? READ : IDLE;
            READ:    state_d = WRITE;
            WRITE:   state_d = RESP;
            RESP:    state_d = resp_ready ? IDLE : RESP;
            default: state_d = IDLE;
        endcase
        if (flush && state_q != IDLE) state_d = IDLE;
    end
    always_comb begin
        op_d     = accept ? req_op       : op_q;
        imm_d    = accept ? req_imm      : imm_q;
        csr_d    = accept ? req_csr      : csr_q;
        rs1_d    = accept ? req_rs1_data : rs1_q;
        zimm_d   = accept ? req_zimm     : zimm_q;
        rs1_x0_d = accept ? req_rs1_x0   : rs1_x0_q;
        rd_x0_d  = accept ? req_rd_x0    : rd_x0_q;
        old_d    = state_q == READ ? csr_data_r : old_q;
    end
    always_comb begin
        req_ready       = state_q == IDLE && !flush;
        accept          = req_valid && req_ready;
        src             = imm_q ? {27'b0, zimm_q} : rs1_q;
        suppress        = op_q != 2'b01 && (imm_q ? zimm_q == 5'd0 : rs1_x0_q);
        ill             = op_q == 2'b00 || (csr_q[11:10] == 2'b11 && !suppress) || priv_ill;
        new_val         = op_q == 2'b01 ? src : op_q == 2'b10 ? (old_q | src) : (old_q & ~src);
        // reset and flush must kill the strobe combinationally, not just on the next edge
        do_write        = state_q == WRITE && !ill && !suppress && !flush && !rst;
        csr_read_index  = state_q == READ ? csr_q : '0;
        csr_write       = do_write;
        csr_write_index = do_write ? csr_q : '0;
        csr_data_w      = do_write ? new_val : '0;
        resp_valid      = state_q == RESP;
        resp_data       = state_q == RESP && !(op_q == 2'b01 && rd_x0_q) ? old_q : '0;
        resp_ill        = state_q == RESP && ill;
    end
endmodule

// File: tb/tb_csr_access_unit.sv
// tb_csr_access_unit: directed self-checking bench for csr_access_unit
module tb_csr_access_unit;
    logic        clk, rst, req_valid, req_ready, req_imm, req_rs1_x0, req_rd_x0, flush;
    logic [1:0]  req_op, cur_priv;
    logic [11:0] req_csr, csr_read_index, csr_write_index;
    logic [31:0] req_rs1_data, csr_data_r, csr_data_w, resp_data;
    logic [4:0]  req_zimm;
    logic        csr_write, resp_valid, resp_ready, resp_ill;
    int          total = 0;
    int          bad = 0;

    csr_access_unit dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_imm(req_imm), .req_csr(req_csr), .req_rs1_data(req_rs1_data),
        .req_zimm(req_zimm), .req_rs1_x0(req_rs1_x0), .req_rd_x0(req_rd_x0), .flush(flush),
        .csr_read_index(csr_read_index), .csr_data_r(csr_data_r),
        .csr_write_index(csr_write_index), .csr_write(csr_write), .csr_data_w(csr_data_w),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .resp_ill(resp_ill), .cur_priv(cur_priv)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // static CSR file contents seen through the read port
    always_comb begin
        case (csr_read_index)
            12'h300: csr_data_r = 32'h0000_0008;
            12'h344: csr_data_r = 32'h0000_0A5A;
            12'hC00: csr_data_r = 32'h1234_5678;
            12'h305: csr_data_r = 32'h0000_0100;
            default: csr_data_r = 32'hDEAD_BEEF;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input logic [1:0] op, input logic imm, input logic [11:0] csr,
                           input logic [31:0] rs1, input logic [4:0] zimm, input logic rs1x0, input logic rdx0);
        req_op = op; req_imm = imm; req_csr = csr; req_rs1_data = rs1;
        req_zimm = zimm; req_rs1_x0 = rs1x0; req_rd_x0 = rdx0;
    endtask

    task automatic access(input string tag, input logic [1:0] op, input logic imm, input logic [11:0] csr,
                          input logic [31:0] rs1, input logic [4:0] zimm, input logic rs1x0, input logic rdx0,
                          input logic we, input logic [31:0] wd, input logic [31:0] rd, input logic il);
        @(negedge clk);
        set_req(op, imm, csr, rs1, zimm, rs1x0, rdx0);
        req_valid = 1'b1;
        #1 chk({tag, ".ready"}, req_ready, 1);
        @(negedge clk);
        req_valid = 1'b0;
        #1 chk({tag, ".rd_idx"}, csr_read_index, csr);
        chk({tag, ".no_we_read"}, csr_write, 0);
        @(negedge clk);
        #1 chk({tag, ".we"}, csr_write, we);
        chk({tag, ".wdata"}, csr_data_w, we ? wd : 32'h0);
        chk({tag, ".widx"}, csr_write_index, we ? csr : 12'h0);
        @(negedge clk);
        #1 chk({tag, ".rvalid"}, resp_valid, 1);
        chk({tag, ".rdata"}, resp_data, rd);
        chk({tag, ".ill"}, resp_ill, il);
        chk({tag, ".busy"}, req_ready, 0);
        @(negedge clk);
        #1 chk({tag, ".rvalid_off"}, resp_valid, 0);
        chk({tag, ".idle"}, req_ready, 1);
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; flush = 1'b0; resp_ready = 1'b1; cur_priv = 2'b11;
        set_req(2'b00, 1'b0, 12'h0, 32'h0, 5'h0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1 chk("rst.rvalid", resp_valid, 0);
        chk("rst.rdata", resp_data, 0);
        chk("rst.ill", resp_ill, 0);
        chk("rst.we", csr_write, 0);
        chk("rst.widx", csr_write_index, 0);
        chk("rst.wdata", csr_data_w, 0);
        chk("rst.ridx", csr_read_index, 0);
        chk("rst.ready", req_ready, 1);

        access("rs_300",   2'b10, 1'b0, 12'h300, 32'h0000_0080, 5'd0,  1'b0, 1'b0, 1'b1, 32'h0000_0088, 32'h0000_0008, 1'b0);
        access("rci_344",  2'b11, 1'b1, 12'h344, 32'hFFFF_FFFF, 5'd0,  1'b0, 1'b0, 1'b0, 32'h0,         32'h0000_0A5A, 1'b0);
        access("rw_c00",   2'b01, 1'b0, 12'hC00, 32'h0000_0001, 5'd0,  1'b0, 1'b0, 1'b0, 32'h0,         32'h1234_5678, 1'b1);
        access("rsx0_c00", 2'b10, 1'b0, 12'hC00, 32'h0000_00FF, 5'd0,  1'b1, 1'b0, 1'b0, 32'h0,         32'h1234_5678, 1'b0);
        access("rw_rdx0",  2'b01, 1'b0, 12'h305, 32'hCAFE_0000, 5'd0,  1'b0, 1'b1, 1'b1, 32'hCAFE_0000, 32'h0,         1'b0);
        access("rc_300",   2'b11, 1'b0, 12'h300, 32'h0000_000C, 5'd0,  1'b0, 1'b0, 1'b1, 32'h0,         32'h0000_0008, 1'b0);
        access("rsi_344",  2'b10, 1'b1, 12'h344, 32'h0,         5'h11, 1'b0, 1'b0, 1'b1, 32'h0000_0A5B, 32'h0000_0A5A, 1'b0);
        access("op00",     2'b00, 1'b0, 12'h300, 32'h0000_0001, 5'd0,  1'b0, 1'b0, 1'b0, 32'h0,         32'h0000_0008, 1'b1);

        // flush during WRITE of an RW to 0x305
        @(negedge clk);
        set_req(2'b01, 1'b0, 12'h305, 32'h0000_0055, 5'd0, 1'b0, 1'b0);
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        flush = 1'b1;
        #1 chk("flw.we", csr_write, 0);
        chk("flw.wdata", csr_data_w, 0);
        chk("flw.widx", csr_write_index, 0);
        @(negedge clk);
        flush = 1'b0;
        #1 chk("flw.ready", req_ready, 1);
        chk("flw.rvalid", resp_valid, 0);
        @(negedge clk);
        #1 chk("flw.rvalid2", resp_valid, 0);

        // response back-pressure with a competing request
        @(negedge clk);
        set_req(2'b10, 1'b0, 12'h300, 32'h0000_0080, 5'd0, 1'b0, 1'b0);
        req_valid = 1'b1;
        resp_ready = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        #1 chk("stall.we", csr_write, 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            set_req(2'b01, 1'b0, 12'h305, 32'h0000_0077, 5'd0, 1'b0, 1'b0);
            req_valid = 1'b1;
            #1 chk("stall.rvalid", resp_valid, 1);
            chk("stall.rdata", resp_data, 32'h0000_0008);
            chk("stall.ill", resp_ill, 0);
            chk("stall.ready", req_ready, 0);
        end
        @(negedge clk);
        resp_ready = 1'b1;
        #1 chk("hs.rvalid", resp_valid, 1);
        @(negedge clk);
        #1 chk("hs.not_acc", csr_read_index, 0);
        chk("hs.ready", req_ready, 1);
        chk("hs.rvalid_off", resp_valid, 0);
        @(negedge clk);
        req_valid = 1'b0;
        #1 chk("hs.acc_next", csr_read_index, 12'h305);
        flush = 1'b1;
        #1 chk("flr.we", csr_write, 0);
        @(negedge clk);
        flush = 1'b0;
        #1 chk("flr.ready", req_ready, 1);
        chk("flr.rvalid", resp_valid, 0);
        @(negedge clk);
        #1 chk("flr.we2", csr_write, 0);
        chk("flr.rvalid2", resp_valid, 0);

        // flush in IDLE blocks a same-cycle request
        @(negedge clk);
        set_req(2'b01, 1'b0, 12'h300, 32'h0000_0001, 5'd0, 1'b0, 1'b0);
        req_valid = 1'b1;
        flush = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        flush = 1'b0;
        #1 chk("fli.ridx", csr_read_index, 0);
        chk("fli.ready", req_ready, 1);

        // reset during WRITE
        @(negedge clk);
        set_req(2'b01, 1'b0, 12'h305, 32'h0000_0099, 5'd0, 1'b0, 1'b0);
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1 chk("rsw.we", csr_write, 0);
        chk("rsw.wdata", csr_data_w, 0);
        @(negedge clk);
        rst = 1'b0;
        #1 chk("rsw.ready", req_ready, 1);
        chk("rsw.rvalid", resp_valid, 0);
        @(negedge clk);
        #1 chk("rsw.we2", csr_write, 0);
        chk("rsw.rvalid2", resp_valid, 0);

        // privilege check: user mode touching a machine CSR
        cur_priv = 2'b00;
`ifdef CSR_PRIV_CHECK_EN
        access("priv_300", 2'b01, 1'b0, 12'h300, 32'h0000_1234, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0000_0008, 1'b1);
`else
        access("priv_300", 2'b01, 1'b0, 12'h300, 32'h0000_1234, 5'd0, 1'b0, 1'b0, 1'b1, 32'h0000_1234, 32'h0000_0008, 1'b0);
`endif
        cur_priv = 2'b11;
        access("priv_m",   2'b01, 1'b0, 12'h300, 32'h0000_4321, 5'd0, 1'b0, 1'b0, 1'b1, 32'h0000_4321, 32'h0000_0008, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/csr_access_unit.md
CSR_ACCESS_UNIT -- requirements
Module: csr_access_unit

Interface
REQ-001 The block SHALL have these ports (name, direction, width, meaning):
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  CSR instruction request present.
- req_ready  out  1  unit can accept a request.
- req_op  in  2  operation: 01 = RW, 10 = RS, 11 = RC; 00 is illegal.
- req_imm  in  1  use req_zimm instead of req_rs1_data as the source.
- req_csr  in  12  CSR address.
- req_rs1_data  in  32  register source operand.
- req_zimm  in  5  immediate source, zero-extended to 32 bits.
- req_rs1_x0  in  1  rs1 field is x0.
- req_rd_x0  in  1  rd field is x0.
- flush  in  1  pipeline flush; abort any in-flight access.
- csr_read_index  out  12  CSR read address.
- csr_data_r  in  32  CSR read data, combinational from csr_read_index.
- csr_write_index  out  12  CSR write address.
- csr_write  out  1  one-cycle write strobe.
- csr_data_w  out  32  CSR write data.
- resp_valid  out  1  result available.
- resp_ready  in  1  consumer accepts the result.
- resp_data  out  32  old CSR value, destined for rd.
- resp_ill  out  1  illegal-instruction flag for this access.
- cur_priv  in  2  current privilege level (used only under CSR_PRIV_CHECK_EN).

Function
REQ-002 The FSM SHALL have the states IDLE, READ, WRITE and RESP.
REQ-003 req_ready SHALL be 1 only in IDLE; a request is accepted when req_valid and req_ready are both 1.
REQ-004 On acceptance, the block SHALL latch all req_* fields and move to READ.
REQ-005 In READ, csr_read_index SHALL equal the latched CSR address, and csr_data_r SHALL be captured into the old-value register at the end of the cycle.
REQ-006 The block SHALL compute the new value from the old value and the source as follows:
- RW: new = src.
- RS: new = old | src.
- RC: new = old & ~src.
REQ-007 Write suppression: RS and RC SHALL NOT write when req_rs1_x0 = 1 (register form) or req_zimm = 0 (immediate form).
REQ-008 RW with req_rd_x0 = 1 SHALL still perform the write and SHALL return resp_data = 0.
REQ-009 An access SHALL be illegal when req_op = 00, or when req_csr[11:10] = 11 and a write is not suppressed.
REQ-010 An illegal access SHALL never assert csr_write and SHALL set resp_ill = 1.
REQ-011 In WRITE, csr_write SHALL be 1 for exactly one cycle only if the access is legal and not suppressed; csr_write_index and csr_data_w SHALL hold the address and the new value.
REQ-012 csr_write SHALL be 0 in all other states, and csr_data_w / csr_write_index SHALL be 0 whenever csr_write = 0.
REQ-013 In RESP, resp_valid SHALL be 1 and resp_data / resp_ill SHALL be stable until resp_ready = 1; the FSM then returns to IDLE.
REQ-014 Latency SHALL be: acceptance in cycle N, READ in N+1, WRITE in N+2, resp_valid first asserted in N+3.
REQ-015 Flush in any non-IDLE state SHALL force IDLE on the next edge and discard the response.
REQ-016 Flush during WRITE SHALL force csr_write to 0 in that same cycle.
REQ-017 Flush in IDLE SHALL have no effect, and a request in the same cycle SHALL NOT be accepted.
REQ-018 A request presented in the same cycle as the RESP handshake SHALL NOT be accepted; acceptance occurs at the earliest on the following IDLE cycle.

Reset
REQ-019 While rst = 1 at a clock edge, the state SHALL become IDLE and all latched fields SHALL clear to 0.
REQ-020 After reset, resp_valid, resp_data, resp_ill, csr_write, csr_write_index, csr_data_w and csr_read_index SHALL be 0, and req_ready SHALL be 1.
REQ-021 Reset asserted mid-access SHALL abort the access with no csr_write pulse in the reset cycle or later.

Configuration
REQ-022 With the macro CSR_PRIV_CHECK_EN defined, an access SHALL also be illegal when req_csr[9:8] > cur_priv.
REQ-023 Without CSR_PRIV_CHECK_EN, cur_priv SHALL be ignored and no privilege check SHALL be made.

Verification
REQ-024 RS on CSR 0x300 with old = 0x0000_0008 and rs1 = 0x0000_0080 -> csr_write pulses in N+2 with data 0x0000_0088; resp_data = 0x0000_0008 in N+3.
REQ-025 RC immediate on CSR 0x344 with zimm = 0 -> no csr_write, resp_data = old value, resp_ill = 0.
REQ-026 RW on read-only CSR 0xC00 -> no csr_write, resp_ill = 1; RS with rs1 = x0 on 0xC00 -> legal read, resp_ill = 0.
REQ-027 Flush asserted in WRITE of an RW to 0x305 -> csr_write stays 0, resp_valid never asserts, req_ready = 1 next cycle.
REQ-028 resp_ready held 0 for 5 cycles -> resp_valid and resp_data stay stable; req_valid asserted meanwhile is not accepted.
REQ-029 With CSR_PRIV_CHECK_EN, cur_priv = 00 and access to 0x300 -> resp_ill = 1, no write; the same stimulus without the macro -> legal write.
